// File: rtl/intersection_ctrl_pkg.sv
// Shared types for the two-approach intersection controller: phase encoding,
// lamp bundles and the phase-to-lamp decode used by the output stage.
package tl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_GREEN,
        A_YELLOW,
        A_ALLRED,
        B_GREEN,
        B_YELLOW,
        B_ALLRED,
        PED_WALK = 3'd7
    } phase_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    typedef struct packed {
        lamp_t a;
        lamp_t b;
    } lamp_pair_t;

    // Exactly one lamp per head in every active phase; IDLE leaves both dark.
    function automatic lamp_pair_t phase_to_lamps(input phase_t phase);
        lamp_pair_t lamps;
        lamps = '0;
        case (phase)
            A_GREEN:  begin lamps.a.green  = 1'b1; lamps.b.red    = 1'b1; end
            A_YELLOW: begin lamps.a.yellow = 1'b1; lamps.b.red    = 1'b1; end
            B_GREEN:  begin lamps.a.red    = 1'b1; lamps.b.green  = 1'b1; end
            B_YELLOW: begin lamps.a.red    = 1'b1; lamps.b.yellow = 1'b1; end
            A_ALLRED, B_ALLRED, PED_WALK: begin
                lamps.a.red = 1'b1;
                lamps.b.red = 1'b1;
            end
            default: lamps = '0;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/intersection_ctrl_if.sv
// Control/duration/lamp bundle between a supervisor (master) and the
// intersection controller (slave).
interface intersection_ctrl_if #(parameter int WIDTH = 32);
    logic             start;
    logic             maintenance;
    logic [WIDTH-1:0] green_a_duration;
    logic [WIDTH-1:0] green_b_duration;
    logic [WIDTH-1:0] yellow_duration;
    logic [WIDTH-1:0] allred_duration;
    logic [WIDTH-1:0] walk_duration;
    logic             ped_req;
    logic             ped_ack;
    logic             walk;
    logic             a_red, a_yellow, a_green;
    logic             b_red, b_yellow, b_green;

    modport master (
        output start, maintenance, green_a_duration, green_b_duration,
               yellow_duration, allred_duration, walk_duration, ped_req,
        input  ped_ack, walk, a_red, a_yellow, a_green, b_red, b_yellow, b_green
    );

    modport slave (
        input  start, maintenance, green_a_duration, green_b_duration,
               yellow_duration, allred_duration, walk_duration, ped_req,
        output ped_ack, walk, a_red, a_yellow, a_green, b_red, b_yellow, b_green
    );
endinterface

// File: rtl/intersection_ctrl_phase_timer.sv
// Shared phase down-counter: loads max(duration,1)-1 at phase entry, freezes
// while hold is high, and flags expiry when the count reaches zero.
module phase_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             hold,
    output logic             expired
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!hold) begin
            if (load) begin
                // A zero duration behaves like one cycle
                r_count <= (load_value == '0) ? '0 : load_value - ONE;
            end else if (r_count != '0) begin
                r_count <= r_count - ONE;
            end
        end
    end

    assign expired = (r_count == '0);
endmodule

// File: rtl/intersection_ctrl.sv
// Two-approach intersection sequencer with all-red clearance. Defining
// PED_REQ_EN adds the pedestrian walk phase served after B_ALLRED on request.
module intersection_ctrl
    import tl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    intersection_ctrl_if.slave bus
);
    phase_t           r_state;
    phase_t           w_state_next;
    logic             w_expired;
    logic             w_load;
    logic [WIDTH-1:0] w_load_value;
    lamp_pair_t       w_lamps;
`ifdef PED_REQ_EN
    logic             r_ped_pending;
    logic             r_ped_ack;
    logic             w_ped_entry;

    assign w_ped_entry = !bus.maintenance && (w_state_next == PED_WALK) && (r_state != PED_WALK);
`else
    logic             w_unused;

    assign w_unused = &{1'b0, bus.ped_req, bus.walk_duration};
`endif

    phase_timer #(.WIDTH(WIDTH)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_value (w_load_value),
        .hold       (bus.maintenance),
        .expired    (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
`ifdef PED_REQ_EN
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
`ifdef PED_REQ_EN
            r_ped_ack     <= w_ped_entry;
            if (!bus.maintenance) begin
                if (!bus.start || w_ped_entry)
                    r_ped_pending <= 1'b0;
                else if (bus.ped_req && r_state != IDLE && r_state != PED_WALK)
                    r_ped_pending <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.maintenance) begin
            w_state_next = r_state;
        end else if (!bus.start) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:     w_state_next = A_GREEN;
                A_GREEN:  if (w_expired) w_state_next = A_YELLOW;
                A_YELLOW: if (w_expired) w_state_next = A_ALLRED;
                A_ALLRED: if (w_expired) w_state_next = B_GREEN;
                B_GREEN:  if (w_expired) w_state_next = B_YELLOW;
                B_YELLOW: if (w_expired) w_state_next = B_ALLRED;
`ifdef PED_REQ_EN
                // A request arriving in the final clearance cycle still counts
                B_ALLRED: if (w_expired) w_state_next = (r_ped_pending || bus.ped_req) ? PED_WALK : A_GREEN;
                PED_WALK: if (w_expired) w_state_next = A_GREEN;
`else
                B_ALLRED: if (w_expired) w_state_next = A_GREEN;
`endif
                default:  w_state_next = IDLE;
            endcase
        end

        // Reload on every phase change, and zero the timer while idle
        w_load = !bus.maintenance && ((w_state_next != r_state) || (w_state_next == IDLE));
        case (w_state_next)
            A_GREEN:            w_load_value = bus.green_a_duration;
            B_GREEN:            w_load_value = bus.green_b_duration;
            A_YELLOW, B_YELLOW: w_load_value = bus.yellow_duration;
            A_ALLRED, B_ALLRED: w_load_value = bus.allred_duration;
`ifdef PED_REQ_EN
            PED_WALK:           w_load_value = bus.walk_duration;
`endif
            default:            w_load_value = '0;
        endcase
    end

    always_comb begin
        w_lamps      = phase_to_lamps(r_state);
        bus.a_red    = w_lamps.a.red;
        bus.a_yellow = w_lamps.a.yellow;
        bus.a_green  = w_lamps.a.green;
        bus.b_red    = w_lamps.b.red;
        bus.b_yellow = w_lamps.b.yellow;
        bus.b_green  = w_lamps.b.green;
`ifdef PED_REQ_EN
        bus.walk     = (r_state == PED_WALK);
        bus.ped_ack  = r_ped_ack;
`else
        bus.walk     = 1'b0;
        bus.ped_ack  = 1'b0;
`endif
        if (bus.maintenance) begin
            bus.a_red    = 1'b1;
            bus.a_yellow = 1'b0;
            bus.a_green  = 1'b0;
            bus.b_red    = 1'b1;
            bus.b_yellow = 1'b0;
            bus.b_green  = 1'b0;
            bus.walk     = 1'b0;
            bus.ped_ack  = 1'b0;
        end
    end
endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed, table-driven bench for intersection_ctrl; walk expectations
// follow whether PED_REQ_EN is defined for the build.
module tb_intersection_ctrl;
    localparam int WIDTH = 32;

    // {a_red, a_yellow, a_green, b_red, b_yellow, b_green}
    localparam logic [5:0] L_IDLE = 6'b000000;
    localparam logic [5:0] L_AG   = 6'b001100;
    localparam logic [5:0] L_AY   = 6'b010100;
    localparam logic [5:0] L_RR   = 6'b100100;
    localparam logic [5:0] L_BG   = 6'b100001;
    localparam logic [5:0] L_BY   = 6'b100010;

    typedef struct {
        logic       start;
        logic       maint;
        logic       ped;
        logic [5:0] lamps;
        logic       walk;
        logic       ack;
        int         reps;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    vec_t vec[$];

    intersection_ctrl_if #(.WIDTH(WIDTH)) bus ();

    intersection_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [5:0] lamps, input logic w, input logic a);
        logic [7:0] act;
        logic [7:0] exp;
        act = {bus.a_red, bus.a_yellow, bus.a_green, bus.b_red, bus.b_yellow, bus.b_green, bus.walk, bus.ped_ack};
        exp = {lamps, w, a};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: lamps/walk/ack got %b want %b at %0t", name, act, exp, $time);
        end
        checks++;
        if (bus.a_green === 1'b1 && bus.b_green === 1'b1) begin
            errors++;
            $display("FAIL %s green_overlap: a_green=%b b_green=%b want not both 1", name, bus.a_green, bus.b_green);
        end
    endtask

    task automatic add(input logic s, input logic m, input logic p, input logic [5:0] l,
                       input logic w, input logic a, input int r);
        vec_t v;
        v.start = s; v.maint = m; v.ped = p; v.lamps = l; v.walk = w; v.ack = a; v.reps = r;
        vec.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vec[i]) begin
            bus.start       = vec[i].start;
            bus.maintenance = vec[i].maint;
            bus.ped_req     = vec[i].ped;
            for (int k = 0; k < vec[i].reps; k++) begin
                step();
                check_out($sformatf("%s_row%0d_cyc%0d", tag, i, k), vec[i].lamps, vec[i].walk, vec[i].ack);
            end
            $display("%s row %0d: start=%0d maint=%0d ped=%0d lamps=%b walk=%0d ack=%0d x%0d",
                     tag, i, vec[i].start, vec[i].maint, vec[i].ped, vec[i].lamps, vec[i].walk, vec[i].ack, vec[i].reps);
        end
        vec.delete();
    endtask

    task automatic set_dur(input int ga, input int gb, input int y, input int ar, input int w);
        bus.green_a_duration = WIDTH'(ga);
        bus.green_b_duration = WIDTH'(gb);
        bus.yellow_duration  = WIDTH'(y);
        bus.allred_duration  = WIDTH'(ar);
        bus.walk_duration    = WIDTH'(w);
    endtask

    initial begin
        logic [2:0] st;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.start = 1'b0;
        bus.maintenance = 1'b0;
        bus.ped_req = 1'b0;
        set_dur(5, 4, 2, 1, 3);

        #1;
        check_out("reset_out", L_IDLE, 1'b0, 1'b0);
        step();
        st = dut.r_state;
        checks++;
        if (st !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", st);
        end
        rst_n = 1'b1;
        $display("reset released");

        // Full rotation, start drop mid-yellow, restart
        add(1, 0, 0, L_AG, 0, 0, 5); add(1, 0, 0, L_AY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_BG, 0, 0, 4); add(1, 0, 0, L_BY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_AG, 0, 0, 5); add(1, 0, 0, L_AY, 0, 0, 1); add(0, 0, 0, L_IDLE, 0, 0, 2);
        add(1, 0, 0, L_AG, 0, 0, 5); add(1, 0, 0, L_AY, 0, 0, 2); add(0, 0, 0, L_IDLE, 0, 0, 1);
        run_vecs("rotation");

        // Zero green_a duration lasts one cycle
        set_dur(0, 4, 2, 1, 3);
        add(1, 0, 0, L_AG, 0, 0, 1); add(1, 0, 0, L_AY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_BG, 0, 0, 1); add(0, 0, 0, L_IDLE, 0, 0, 1);
        run_vecs("zero_dur");

        // Maintenance freeze 3 cycles into a 10-cycle green; start falls while frozen
        set_dur(10, 4, 2, 1, 3);
        add(1, 0, 0, L_AG, 0, 0, 3); add(1, 1, 0, L_RR, 0, 0, 18); add(0, 1, 0, L_RR, 0, 0, 2);
        add(1, 0, 0, L_AG, 0, 0, 7); add(1, 0, 0, L_AY, 0, 0, 1); add(0, 0, 0, L_IDLE, 0, 0, 1);
        run_vecs("maint");

        // Pedestrian request pulsed during B_GREEN
        set_dur(5, 4, 2, 1, 3);
        add(1, 0, 0, L_AG, 0, 0, 5); add(1, 0, 0, L_AY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_BG, 0, 0, 1); add(1, 0, 1, L_BG, 0, 0, 1); add(1, 0, 0, L_BG, 0, 0, 2);
        add(1, 0, 0, L_BY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
`ifdef PED_REQ_EN
        add(1, 0, 0, L_RR, 1, 1, 1); add(1, 0, 0, L_RR, 1, 0, 2);
`endif
        add(1, 0, 0, L_AG, 0, 0, 5); add(1, 0, 0, L_AY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_BG, 0, 0, 4); add(1, 0, 0, L_BY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_AG, 0, 0, 1);
        run_vecs("ped_walk");

        // Request pending when start drops mid-B_YELLOW; not served after restart
        add(1, 0, 0, L_AG, 0, 0, 4); add(1, 0, 0, L_AY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_BG, 0, 0, 1); add(1, 0, 1, L_BG, 0, 0, 1); add(1, 0, 0, L_BG, 0, 0, 2);
        add(1, 0, 0, L_BY, 0, 0, 1); add(0, 0, 1, L_IDLE, 0, 0, 1);
        add(1, 0, 0, L_AG, 0, 0, 5); add(1, 0, 0, L_AY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_BG, 0, 0, 4); add(1, 0, 0, L_BY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        add(1, 0, 0, L_AG, 0, 0, 1); add(0, 0, 0, L_IDLE, 0, 0, 1);
        run_vecs("drop_pending");

        // Asynchronous reset in the middle of A_ALLRED
        add(1, 0, 0, L_AG, 0, 0, 5); add(1, 0, 0, L_AY, 0, 0, 2); add(1, 0, 0, L_RR, 0, 0, 1);
        run_vecs("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset_out", L_IDLE, 1'b0, 1'b0);
        st = dut.r_state;
        checks++;
        if (st !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_state: got %0d want 0", st);
        end
        $display("async reset asserted mid A_ALLRED");
        step();
        rst_n = 1'b1;
        step();
        check_out("after_reset_first", L_AG, 1'b0, 1'b0);
        $display("restart after async reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
